ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (LED set, reset, typematic, ...) from the FPGA to the keyboard over the shared open-drain PS2Clk/PS2Data lines. It sits beside `ps2_rx` under `keyboard`. While a transmission is in progress it drives `rx_en` low so the receiver ignores host-generated traffic.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_clk_filter.sv | 54 +++++
 rtl/ps2_host_tx.sv | 145 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command constants
// and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RTS,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_ACK_WAIT
  } tx_state_e;

  localparam logic [7:0] BREAK       = 8'hF0;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] ACK         = 8'hFA;

  // Odd parity bit: total count of ones over data + parity is odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS2Clk glitch filter with falling-edge pulse, plus a 2-flop PS2Data
// synchronizer. The shift register doubles as the clock synchronizer.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2clk_in,
  input  logic ps2data_in,
  output logic clk_filt,
  output logic data_sync,
  output logic fall
);

  logic [FILTER_LEN-1:0] sr_q, sr_d;
  logic [1:0]            dsync_q, dsync_d;
  logic                  filt_q, filt_d;
  logic                  fall_q, fall_d;

  // Filtered level only changes once the whole window agrees.
  always_comb begin
    sr_d    = {ps2clk_in, sr_q[FILTER_LEN-1:1]};
    dsync_d = {dsync_q[0], ps2data_in};
    filt_d  = filt_q;
    if (&sr_q) begin
      filt_d = 1'b1;
    end else if (~|sr_q) begin
      filt_d = 1'b0;
    end
    fall_d = filt_q & ~filt_d;
  end

  // Idle bus is high, so everything resets to the released level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q    <= '1;
      dsync_q <= '1;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      dsync_q <= dsync_d;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
    end
  end

  assign clk_filt  = filt_q;
  assign data_sync = dsync_q[1];
  assign fall      = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by
// the device, ack check and overall timeout. Pad tristates live above this.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       tx_idle,
  output logic       rx_en,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  tx_state_e        state_q, state_d;
  logic [8:0]       shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_filt, data_sync, fall;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2clk_in (PS2Clk),
    .ps2data_in(PS2Data),
    .clk_filt  (clk_filt),
    .data_sync (data_sync),
    .fall      (fall)
  );

  // Next-state logic. One counter serves both the inhibit hold (rts) and
  // the frame timeout (start..ack_wait); expiry is checked before the edge.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_ps2) begin
          shift_d = {odd_parity(din), din};
          cnt_d   = INH_LOAD;
          state_d = ST_RTS;
        end
      end
      ST_RTS: begin
        if (cnt_q == '0) begin
          cnt_d   = TMO_LOAD;
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_START, ST_DATA, ST_STOP, ST_ACK_WAIT: begin
        if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (state_q == ST_START && fall) begin
            bit_d   = 4'd8;
            state_d = ST_DATA;
          end else if (state_q == ST_DATA && fall) begin
            if (bit_q == '0) begin
              state_d = ST_STOP;
            end else begin
              shift_d = {1'b0, shift_q[8:1]};
              bit_d   = bit_q - 4'd1;
            end
          end else if (state_q == ST_STOP && fall) begin
            if (!data_sync) begin
              state_d = ST_ACK_WAIT;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (state_q == ST_ACK_WAIT && clk_filt && data_sync) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Drivers are derived from the next state so they register glitch-free.
    clk_oe_d  = (state_d == ST_RTS);
    data_oe_d = (state_d == ST_START) || ((state_d == ST_DATA) && !shift_d[0]);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2clk_oe    = clk_oe_q;
  assign ps2data_oe   = data_oe_q;
  assign tx_idle      = (state_q == ST_IDLE);
  assign rx_en        = tx_idle;
  assign tx_done_tick = done_q;
  assign tx_err_tick  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with an open-drain bus and a keyboard model that
// clocks frames back; expected frames are queued and checked on completion.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH  = 200;
  localparam int unsigned TMO  = 5000;
  localparam int unsigned FLT  = 8;
  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = '0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2clk_line, ps2data_line;
  logic       ps2clk_oe, ps2data_oe, tx_idle, rx_en, tx_done_tick, tx_err_tick;

  assign ps2clk_line  = dev_clk & ~ps2clk_oe;
  assign ps2data_line = dev_data & ~ps2data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .PS2Clk      (ps2clk_line),
    .PS2Data     (ps2data_line),
    .ps2clk_oe   (ps2clk_oe),
    .ps2data_oe  (ps2data_oe),
    .tx_idle     (tx_idle),
    .rx_en       (rx_en),
    .tx_done_tick(tx_done_tick),
    .tx_err_tick (tx_err_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       parity;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Passive monitor: tick counts, inhibit hold length, release timing.
  int   cyc = 0;
  int   done_cnt = 0, err_cnt = 0;
  int   hold_cnt = 0, hold_len = 0, rel_cyc = 0, err_cyc = 0;
  logic drop_data = 1'b0, prev_oe = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_done_tick) done_cnt++;
    if (tx_err_tick) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (ps2clk_oe) begin
      hold_cnt++;
    end else if (prev_oe) begin
      hold_len  = hold_cnt;
      hold_cnt  = 0;
      drop_data = ps2data_oe;
      rel_cyc   = cyc;
    end
    prev_oe = ps2clk_oe;
  end

  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    din    = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din    = 8'h5A;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(INH) + 50; i++) begin
      @(negedge clk);
      if (ps2data_oe && !ps2clk_oe) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  // One device clock pulse; samples the data line on the rising edge.
  task automatic kbd_clock(input bit glitch, output logic smp);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    smp = ps2data_line;
    repeat (15) @(negedge clk);
    if (glitch) begin
      dev_clk = 1'b0;
      repeat (5) @(negedge clk);
      dev_clk = 1'b1;
    end
    repeat (HALF - 15) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack_ok, input bit glitch,
                           input bit mid_wr);
    exp_t       e, g;
    bit         ok;
    logic       st, smp;
    logic [9:0] bits;
    int         d0, e0;
    e.din    = d;
    e.parity = (($countones(d) % 2) == 0);
    e.ack    = ack_ok;
    sb.push_back(e);
    d0 = done_cnt;
    e0 = err_cnt;
    strobe(d);
    wait_start(ok);
    chk("rts_to_start", 32'(ok), 1);
    chk("inhibit_len", hold_len, INH);
    chk("data_oe_at_release", 32'(drop_data), 1);
    repeat (20) @(negedge clk);
    st = ps2data_line;
    for (int i = 0; i < 10; i++) begin
      kbd_clock(glitch && i == 3, smp);
      bits[i] = smp;
      if (mid_wr && i == 4) strobe(8'h00);
    end
    if (ack_ok) dev_data = 1'b0;
    repeat (10) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    dev_data = 1'b1;
    for (int i = 0; i < 200 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
    @(negedge clk);
    g = sb.pop_front();
    chk("start_bit", 32'(st), 0);
    chk("data_bits", 32'(bits[7:0]), 32'(g.din));
    chk("parity", 32'(bits[8]), 32'(g.parity));
    chk("stop_bit", 32'(bits[9]), 1);
    chk("done_ticks", done_cnt - d0, 32'(g.ack));
    chk("err_ticks", err_cnt - e0, 32'(!g.ack));
    chk("idle_after", 32'(tx_idle), 1);
    chk("rx_en_after", 32'(rx_en), 1);
    chk("lines_released", 32'({ps2clk_oe, ps2data_oe}), 0);
    repeat (30) @(negedge clk);
  endtask

  task automatic timeout_test();
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    strobe(CMD_ENABLE);
    wait_start(ok);
    chk("to_rts_to_start", 32'(ok), 1);
    for (int i = 0; i < int'(TMO) + 100 && err_cnt == e0; i++) @(negedge clk);
    @(negedge clk);
    chk("to_err_ticks", err_cnt - e0, 1);
    chk("to_done_ticks", done_cnt - d0, 0);
    chk("to_latency", err_cyc - rel_cyc, TMO);
    chk("to_lines_released", 32'({ps2clk_oe, ps2data_oe}), 0);
    chk("to_idle", 32'(tx_idle), 1);
    repeat (30) @(negedge clk);
  endtask

  task automatic reset_test();
    bit   ok;
    logic smp;
    strobe(8'h00);
    wait_start(ok);
    chk("rst_rts_to_start", 32'(ok), 1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) kbd_clock(1'b0, smp);
    chk("pre_reset_data_oe", 32'(ps2data_oe), 1);
    #3 reset = 1'b0;
    #1;
    chk("rst_async_oe", 32'({ps2clk_oe, ps2data_oe}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_tx_idle", 32'(tx_idle), 1);
    chk("rst_rx_en", 32'(rx_en), 1);
    repeat (50) @(negedge clk);
    chk("rst_no_resume", 32'({ps2clk_oe, ps2data_oe, tx_idle}), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_oe", 32'({ps2clk_oe, ps2data_oe}), 0);
    chk("reset_idle_rx_en", 32'({tx_idle, rx_en}), 32'h3);
    chk("reset_ticks", 32'({tx_done_tick, tx_err_tick}), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    run_frame(CMD_SET_LED, 1'b1, 1'b0, 1'b0);
    run_frame(8'h01,       1'b1, 1'b0, 1'b0);
    run_frame(CMD_RESET,   1'b1, 1'b0, 1'b0);
    run_frame(CMD_ENABLE,  1'b0, 1'b0, 1'b0);
    run_frame(8'hA5,       1'b1, 1'b1, 1'b1);
    timeout_test();
    reset_test();
    run_frame(BREAK,       1'b1, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
